serial_word_comparator: RTL and testbench

Nibble-serial magnitude comparator for WIDTH-bit words. It walks the operands one nibble per clock, least-significant nibble first. Each nibble's cascaded LT/EQ/GT verdict is registered and fed back as the cascade input for the next, more significant nibble, so one 4-bit compare slice covers any word width. It sits upstream of result consumers and downstream of operand producers, with valid/ready handshakes on both sides.

---
 rtl/cmp_pkg.sv | 34 +++
 rtl/nibble_cmp_stage.sv | 23 ++
 rtl/serial_word_comparator.sv | 147 ++++++++++++++
 tb/tb_serial_word_comparator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the nibble-serial word comparator.
package cmp_pkg;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t CMP_LT   = 3'b100;
  localparam cmp_res_t CMP_EQ   = 3'b010;
  localparam cmp_res_t CMP_GT   = 3'b001;
  localparam cmp_res_t CMP_NONE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  // GT wins over LT; anything else is a neutral (equal) seed.
  function automatic cmp_res_t seed_norm(input logic lt, input logic gt);
    cmp_res_t r;
    if (gt) begin
      r = CMP_GT;
    end else if (lt) begin
      r = CMP_LT;
    end else begin
      r = CMP_EQ;
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_cmp_stage.sv
// Combinational 4-bit magnitude slice with LT/EQ/GT cascade input.
module nibble_cmp_stage
  import cmp_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  cmp_res_t   casc_i,
  output cmp_res_t   res_o
);

  // A decisive nibble overrides the lower-order verdict; equal nibbles pass it on.
  always_comb begin
    res_o = casc_i;
    if (a_i < b_i) begin
      res_o = CMP_LT;
    end else if (a_i > b_i) begin
      res_o = CMP_GT;
    end else begin
      res_o = casc_i;
    end
  end

endmodule

// File: rtl/serial_word_comparator.sv
// Nibble-serial LSB-first magnitude comparator with valid/ready on both sides.
// Define SERIAL_CMP_SIGNED_EN for two's-complement operands (default: unsigned).
module serial_word_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             seed_lt,
  input  logic             seed_eq,
  input  logic             seed_gt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             LTout,
  output logic             EQout,
  output logic             GTout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  cmp_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  cmp_res_t         casc_q, casc_d;
  cmp_res_t         res_q, res_d;
  logic             start_ready_q, start_ready_d;
  logic             res_valid_q, res_valid_d;

  logic             last_s;
  logic [3:0]       nib_a_s;
  logic [3:0]       nib_b_s;
  cmp_res_t         stage_s;
  logic             seed_unused_s;

  // A neutral seed is the default, so the explicit "equal" seed carries no information.
  assign seed_unused_s = seed_eq;

  assign last_s = (cnt_q == CNT_W'(NIBBLES - 1));

`ifdef SERIAL_CMP_SIGNED_EN
  // Flipping both sign bits maps two's complement onto unsigned order for the top nibble.
  assign nib_a_s = {a_sh_q[3] ^ last_s, a_sh_q[2:0]};
  assign nib_b_s = {b_sh_q[3] ^ last_s, b_sh_q[2:0]};
`else
  assign nib_a_s = a_sh_q[3:0];
  assign nib_b_s = b_sh_q[3:0];
`endif

  nibble_cmp_stage u_stage (
    .a_i    (nib_a_s),
    .b_i    (nib_b_s),
    .casc_i (casc_q),
    .res_o  (stage_s)
  );

  // State, datapath and registered-output next-state logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_sh_d        = a_sh_q;
    b_sh_d        = b_sh_q;
    casc_d        = casc_q;
    res_d         = res_q;
    start_ready_d = start_ready_q;
    res_valid_d   = res_valid_q;
    case (state_q)
      IDLE: begin
        if (start_valid && start_ready_q) begin
          a_sh_d        = A;
          b_sh_d        = B;
          casc_d        = seed_norm(seed_lt, seed_gt);
          cnt_d         = '0;
          start_ready_d = 1'b0;
          state_d       = RUN;
        end else begin
          start_ready_d = 1'b1;
        end
      end
      RUN: begin
        casc_d = stage_s;
        a_sh_d = a_sh_q >> 3'd4;
        b_sh_d = b_sh_q >> 3'd4;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_s) begin
          res_d       = stage_s;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d     = RUN;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_d         = CMP_NONE;
          res_valid_d   = 1'b0;
          start_ready_d = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d       = DONE;
        end
      end
      default: begin
        res_d         = CMP_NONE;
        res_valid_d   = 1'b0;
        start_ready_d = 1'b1;
        state_d       = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      a_sh_q        <= '0;
      b_sh_q        <= '0;
      casc_q        <= CMP_NONE;
      res_q         <= CMP_NONE;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      a_sh_q        <= a_sh_d;
      b_sh_q        <= b_sh_d;
      casc_q        <= casc_d;
      res_q         <= res_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign LTout       = res_q.lt;
  assign EQout       = res_q.eq;
  assign GTout       = res_q.gt;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Scoreboard bench: stimulus pushes expected {lt,eq,gt}; a monitor checks each result handshake.
module tb_serial_word_comparator;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

`ifdef SERIAL_CMP_SIGNED_EN
  localparam logic [2:0] EXP_A000 = 3'b100;
  localparam logic [2:0] EXP_8000 = 3'b100;
`else
  localparam logic [2:0] EXP_A000 = 3'b001;
  localparam logic [2:0] EXP_8000 = 3'b001;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             seed_lt;
  logic             seed_eq;
  logic             seed_gt;
  logic             res_valid;
  logic             res_ready;
  logic             LTout;
  logic             EQout;
  logic             GTout;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [2:0]  exp_q[$];
  string       name_q[$];

  serial_word_comparator #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .A           (A),
    .B           (B),
    .seed_lt     (seed_lt),
    .seed_eq     (seed_eq),
    .seed_gt     (seed_gt),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .LTout       (LTout),
    .EQout       (EQout),
    .GTout       (GTout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(posedge clk) begin
    logic [2:0] e;
    string      nm;
    if (reset === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0b expected=none", {LTout, EQout, GTout});
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        pops++;
        chk(nm, {29'd0, LTout, EQout, GTout}, {29'd0, e});
      end
    end
  end

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic slt, input logic seq, input logic sgt);
    bit ok;
    @(negedge clk);
    A = a; B = b; seed_lt = slt; seed_eq = seq; seed_gt = sgt;
    start_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (start_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL start_timeout actual=0 expected=1");
    end
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    A = 16'hFFFF; B = 16'h0000; seed_lt = 1'b1; seed_eq = 1'b0; seed_gt = 1'b0;
  endtask

  task automatic wait_res(input string name);
    int lat;
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, N);
  endtask

  task automatic run(input string name, input logic [15:0] a, input logic [15:0] b,
                     input logic slt, input logic seq, input logic sgt, input logic [2:0] exp);
    exp_q.push_back(exp);
    name_q.push_back(name);
    start_op(a, b, slt, seq, sgt);
    wait_res(name);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_valid = 1'b0; res_ready = 1'b1;
    A = '0; B = '0; seed_lt = 1'b0; seed_eq = 1'b0; seed_gt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_outs", {LTout, EQout, GTout}, 0);
    reset = 1'b0;

    run("lt_lsn",      16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 3'b100);
    run("top_override", 16'hA000, 16'h0FFF, 1'b0, 1'b0, 1'b0, EXP_A000);
    run("seed_gt",     16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b1, 3'b001);
    run("seed_lt",     16'h5A5A, 16'h5A5A, 1'b1, 1'b0, 1'b0, 3'b100);
    run("seed_eq",     16'h5A5A, 16'h5A5A, 1'b0, 1'b1, 1'b0, 3'b010);
    run("seed_prio",   16'h5A5A, 16'h5A5A, 1'b1, 1'b0, 1'b1, 3'b001);
    run("sign_8000",   16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, EXP_8000);

    // Backpressure: result held for 5 cycles while a new start is offered.
    res_ready = 1'b0;
    exp_q.push_back(3'b100);
    name_q.push_back("bp_result");
    start_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    wait_res("bp");
    A = 16'hFFFF; B = 16'h0000; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_outs", {LTout, EQout, GTout}, 3'b100);
      chk("bp_start_ready", start_ready, 0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", res_valid, 0);
    chk("bp_release_outs", {LTout, EQout, GTout}, 0);
    chk("bp_release_ready", start_ready, 1);

    // Reset in the second RUN cycle aborts the compare.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_start_ready", start_ready, 1);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_outs", {LTout, EQout, GTout}, 0);
    @(negedge clk);
    reset = 1'b0;
    run("after_reset", 16'h00FF, 16'h00FE, 1'b0, 1'b0, 1'b0, 3'b001);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("result_count", pops, 9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
